// File: rtl/cascade_ctl.sv
// cascade_ctl: start/stop timer sequencer for a chain of 4-bit digit counters.
// Generates the prescaled tick, ripple-carry enables, modulus selects and the
// counter clear, and stops the chain when the digits reach a programmed target.
module cascade_ctl #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned PRESC = 100,
  parameter int unsigned BCD   = 1
) (
  input  logic              csc_clk,
  input  logic              csc_rst,
  input  logic              csc_start,
  input  logic              csc_stop,
  input  logic              csc_clear,
  input  logic [4*NDIG-1:0] csc_tgt,
  input  logic [4*NDIG-1:0] csc_dig_q,
  output logic [NDIG-1:0]   csc_en,
  output logic [NDIG-1:0]   csc_sel,
  output logic              csc_crst,
  output logic [1:0]        csc_state,
  output logic              csc_done,
  output logic              csc_ovf
);

  localparam int unsigned PW      = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam bit          IS_BCD  = (BCD != 0);
  localparam logic [3:0]  DMAX    = IS_BCD ? 4'd9 : 4'd15;
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [NDIG-1:0] dig_max;
  logic [NDIG:0]   carry;
  logic            tgt_ok;
  logic            match;
  logic            count_ok;
  logic            tick_go;
  logic            crst_c;

  // Per-digit terminal detection, ripple-carry prefix and target match.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    dig_max  = '0;
    tgt_ok   = 1'b1;
    for (int i = 0; i < int'(NDIG); i++) begin
      dig_max[i]   = (csc_dig_q[4*i +: 4] == DMAX);
      carry[i+1]   = carry[i] & dig_max[i];
      // a target digit beyond the modulus can never be reached
      if (csc_tgt[4*i +: 4] > DMAX) tgt_ok = 1'b0;
    end
    match = tgt_ok && (csc_dig_q == csc_tgt);
  end

  // Next-state, prescaler and command decode (clear > stop > start).
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    count_ok = 1'b0;
    crst_c   = 1'b0;
    if (csc_clear) begin
      crst_c  = 1'b1;
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (csc_start) state_d = match ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (csc_stop) begin
            state_d = ST_PAUSE;
          end else if (match) begin
            state_d = ST_DONE;
          end else begin
            count_ok = 1'b1;
            presc_d  = (presc_q == PLAST) ? '0 : PW'(presc_q + 1'b1);
          end
        end
        ST_PAUSE: begin
          if (!csc_stop && csc_start) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Tick qualification, enable chain and registered status inputs.
  always_comb begin
    tick_go = count_ok && (presc_q == PLAST);
    csc_en  = tick_go ? carry[NDIG-1:0] : '0;
    csc_sel = IS_BCD ? csc_en : '0;
    ovf_d   = tick_go && carry[NDIG];
    done_d  = (state_d == ST_DONE);
  end

  // Counter clear is suppressed while the controller itself is in reset.
  assign csc_crst  = crst_c && !csc_rst;
  assign csc_state = state_q;
  assign csc_done  = done_q;
  assign csc_ovf   = ovf_q;

  // State, prescaler and registered status flops.
  always_ff @(posedge csc_clk or posedge csc_rst) begin
    if (csc_rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cascade_ctl.sv
// tb_cascade_ctl: directed bench for cascade_ctl with two BCD digit counters in loop.
module tb_cascade_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clear;
  logic [7:0] tgt;
  logic [7:0] dig = 8'h00;
  logic [1:0] en, sel;
  logic       crst, done, ovf;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;
  int n;

  cascade_ctl #(.NDIG(2), .PRESC(4), .BCD(1)) dut (
    .csc_clk   (clk),
    .csc_rst   (rst),
    .csc_start (start),
    .csc_stop  (stop),
    .csc_clear (clear),
    .csc_tgt   (tgt),
    .csc_dig_q (dig),
    .csc_en    (en),
    .csc_sel   (sel),
    .csc_crst  (crst),
    .csc_state (state),
    .csc_done  (done),
    .csc_ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Two 4-bit digit counters: sync clear, enable, wrap at 9 when sel is high.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (crst)        dig[4*i +: 4] <= 4'd0;
      else if (en[i])  dig[4*i +: 4] <= (sel[i] && dig[4*i +: 4] == 4'd9) ? 4'd0 : dig[4*i +: 4] + 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; tgt = 8'h99;

    // Reset state
    @(negedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_en",    32'(en),    32'd0);
    check("rst_sel",   32'(sel),   32'd0);
    check("rst_crst",  32'(crst),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    @(negedge clk); rst = 1'b0;

    // 1: count 00..10 with carry into digit 1 on the 09 tick
    @(negedge clk); clear = 1'b1; #1;
    check("t1_crst", 32'(crst), 32'd1);
    check("t1_en",   32'(en),   32'd0);
    @(negedge clk); clear = 1'b0; start = 1'b1; #1;
    check("t1_idle", 32'(state), 32'd0);
    check("t1_dig0", 32'(dig),   32'h00);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); start = 1'b0; #1;
      check("t1_en_seq",  32'(en),  32'({k == 40, (k % 4) == 0}));
      check("t1_sel_seq", 32'(sel), 32'({k == 40, (k % 4) == 0}));
      check("t1_dig_seq", 32'(dig), 32'((k - 1) / 4));
    end
    @(negedge clk); #1;
    check("t1_dig10", 32'(dig),   32'h10);
    check("t1_run",   32'(state), 32'd1);

    // 2: stop at target 0x12, DONE ignores start/stop, clear leaves
    @(negedge clk); clear = 1'b1; tgt = 8'h12; #1;
    check("t2_crst", 32'(crst), 32'd1);
    @(negedge clk); clear = 1'b0; start = 1'b1; #1;
    check("t2_dig0", 32'(dig), 32'h00);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk); start = 1'b0; #1;
      n = k;
      if (k == 49) begin
        check("t2_match_dig", 32'(dig), 32'h12);
        check("t2_match_en",  32'(en),  32'd0);
      end
      if (state == 2'b11) break;
    end
    check("t2_done_lat", 32'(n),    32'd50);
    check("t2_done",     32'(done), 32'd1);
    check("t2_dig",      32'(dig),  32'h12);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); start = 1'b1; stop = (k == 2); #1;
      check("t2_hold_state", 32'(state), 32'd3);
      check("t2_hold_en",    32'(en),    32'd0);
    end
    @(negedge clk); start = 1'b0; stop = 1'b0; clear = 1'b1; #1;
    check("t2_clr_crst", 32'(crst), 32'd1);
    @(negedge clk); clear = 1'b0; #1;
    check("t2_crst_off", 32'(crst),  32'd0);
    check("t2_clr_st",   32'(state), 32'd0);
    check("t2_clr_dig",  32'(dig),   32'h00);
    check("t2_clr_done", 32'(done),  32'd0);

    // 3: pause at presc=2, resume keeps prescaler phase
    @(negedge clk); tgt = 8'h99; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); stop = 1'b1; #1;
    check("t3_stop_en", 32'(en), 32'd0);
    @(negedge clk); stop = 1'b0; #1;
    check("t3_pause", 32'(state), 32'd2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("t3_pause_en", 32'(en), 32'd0);
    end
    @(negedge clk); start = 1'b1; #1;
    check("t3_pre_run", 32'(state), 32'd2);
    @(negedge clk); start = 1'b0; #1;
    check("t3_rerun",  32'(state), 32'd1);
    check("t3_rerun0", 32'(en),    32'd0);
    @(negedge clk); #1;
    check("t3_tick", 32'(en), 32'd1);
    @(negedge clk); #1;
    check("t3_dig01", 32'(dig), 32'h01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); stop = 1'b1; #1;
    check("t3_stop_tick_en", 32'(en), 32'd0);
    @(negedge clk); stop = 1'b0; #1;
    check("t3_pause2",   32'(state), 32'd2);
    check("t3_dig_held", 32'(dig),   32'h01);

    // 4: unreachable target, full-chain wrap 99 -> 00 with ovf pulse
    @(negedge clk); clear = 1'b1; tgt = 8'hAA;
    @(negedge clk); clear = 1'b0; start = 1'b1;
    n = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk); start = 1'b0; #1;
      n = k;
      if (dig == 8'h99) break;
    end
    check("t4_reach99", 32'(n), 32'd397);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      n = k;
      if (en != 2'b00) break;
    end
    check("t4_wrap_lat", 32'(n),     32'd3);
    check("t4_wrap_en",  32'(en),    32'd3);
    check("t4_wrap_sel", 32'(sel),   32'd3);
    check("t4_ovf_pre",  32'(ovf),   32'd0);
    @(negedge clk); #1;
    check("t4_ovf",   32'(ovf),   32'd1);
    check("t4_dig00", 32'(dig),   32'h00);
    check("t4_run",   32'(state), 32'd1);
    @(negedge clk); #1;
    check("t4_ovf_off", 32'(ovf), 32'd0);

    // 5: command priority in RUN and PAUSE
    @(negedge clk); start = 1'b1; stop = 1'b1; clear = 1'b1; #1;
    check("t5_crst", 32'(crst), 32'd1);
    check("t5_en",   32'(en),   32'd0);
    @(negedge clk); clear = 1'b0; stop = 1'b0; start = 1'b1; #1;
    check("t5_idle", 32'(state), 32'd0);
    @(negedge clk); start = 1'b0; stop = 1'b1; #1;
    check("t5_run", 32'(state), 32'd1);
    @(negedge clk); start = 1'b1; stop = 1'b1; #1;
    check("t5_pause", 32'(state), 32'd2);
    @(negedge clk); start = 1'b0; stop = 1'b0; #1;
    check("t5_pause_hold", 32'(state), 32'd2);
    check("t5_crst_off",   32'(crst),  32'd0);

    // 6: async reset mid-run, counters keep their value
    @(negedge clk); clear = 1'b1; tgt = 8'h99;
    @(negedge clk); clear = 1'b0; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); start = 1'b0;
    end
    #1 rst = 1'b1; #1;
    check("t6_state", 32'(state), 32'd0);
    check("t6_en",    32'(en),    32'd0);
    check("t6_sel",   32'(sel),   32'd0);
    check("t6_crst",  32'(crst),  32'd0);
    check("t6_done",  32'(done),  32'd0);
    check("t6_ovf",   32'(ovf),   32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b1; #1;
    check("t6_dig_kept", 32'(dig), 32'h01);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); start = 1'b0; #1;
      n = k;
      if (en != 2'b00) break;
    end
    check("t6_tick_lat", 32'(n), 32'd4);
    @(negedge clk); #1;
    check("t6_dig02", 32'(dig), 32'h02);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
